// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with bubble-on-flush and stall counter.
// Optional macro PIPE_SKID_EN adds a skid slot and a registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 143,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic in_fire;
  logic stall;

  assign in_fire = in_valid && in_ready;
  assign stall   = out_valid && !out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              main_free;

  assign in_ready  = !skid_valid;
  assign main_free = !out_valid || out_ready;

  // Main and skid slots; skid drains into main ahead of new input.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end
`else
  logic out_fire;

  assign in_ready = out_ready || !out_valid;
  assign out_fire = out_valid && out_ready;

  // Single slot: load on input, go to a zero-control bubble when drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end
`endif

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes accepted beats,
// monitor pops and compares on every output transfer.
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  logic [CW+DW-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  logic fired;
  logic kill;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // One clock: sample transfers at negedge, settle #1 after posedge.
  task automatic step();
    @(negedge clk);
    fired = in_valid && in_ready;
    if (fired && !flush && !reset)
      exp_q.push_back({in_ctrl, in_data});
    kill = flush || reset;
    @(posedge clk);
    #1;
    if (kill) exp_q.delete();
  endtask

  // Monitor: compare every delivered beat, and bubble control.
  always @(negedge clk) begin
    logic [CW+DW-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_beat got=%0h want=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_ctrl", 64'(out_ctrl), 64'(e[CW+DW-1:DW]));
        chk("beat_data", 64'(out_data), 64'(e[DW-1:0]));
      end
    end
    if (out_valid === 1'b0)
      chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
  end

`ifdef PIPE_SKID_EN
  logic [8:0] rdy_pat = 9'b111111001;
  logic [8:0] ir_exp  = 9'b111110011;
`endif

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_ctrl = '0; in_data = '0; out_ready = 1'b1;

    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
    end
    reset = 1'b0;

    // stream 1,2,3 with latency 1
    in_valid = 1'b1; in_ctrl = 10'h3FF;
    for (int i = 1; i <= 3; i++) begin
      in_data = DW'(i);
      step();
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_data", 64'(out_data), 64'(i));
      chk("lat_ctrl", 64'(out_ctrl), 64'h3FF);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // stall hold on 0xA
    in_valid = 1'b1; in_ctrl = 10'h155; in_data = 16'hA;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("hold_data", 64'(out_data), 64'hA);
      chk("hold_ctrl", 64'(out_ctrl), 64'h155);
      chk("hold_cnt", 64'(stall_cnt), 64'(i));
    end
    out_ready = 1'b1;
    step();
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_cnt", 64'(stall_cnt), 64'd5);

    // flush: 0xB delivered in flush cycle, 0xC dropped
    in_valid = 1'b1; in_ctrl = 10'h0F0; in_data = 16'hB;
    step();
    in_data = 16'hC; flush = 1'b1;
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("postflush_valid", 64'(out_valid), 64'd0);

    // flush while stalled; flush cycle itself is a stall cycle
    in_valid = 1'b1; in_data = 16'hD;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("stall6_cnt", 64'(stall_cnt), 64'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fstall_valid", 64'(out_valid), 64'd0);
    chk("fstall_cnt", 64'(stall_cnt), 64'd7);

    // saturation at 15
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hE;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 64'(stall_cnt), 64'd15);
    chk("sat_data", 64'(out_data), 64'hE);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_flush_cnt", 64'(stall_cnt), 64'd15);
    chk("sat_flush_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat_rst_cnt", 64'(stall_cnt), 64'd0);
    out_ready = 1'b1;

`ifdef PIPE_SKID_EN
    // skid: input 1..6, out_ready 1,0,0,1,1,1 then high
    begin
      int idx = 1;
      logic ir0;
      in_ctrl = 10'h2AA;
      for (int c = 0; c < 9; c++) begin
        in_valid = (idx <= 6);
        in_data = DW'(idx);
        ir0 = in_ready;
        out_ready = rdy_pat[c];
        #1;
        chk("skid_ir_stable", 64'(in_ready), 64'(ir0));
        chk("skid_ir", 64'(in_ready), 64'(ir_exp[c]));
        step();
        if (fired && in_valid) idx++;
      end
      in_valid = 1'b0;
      chk("skid_count", 64'(idx), 64'd7);
      step();
    end
`endif

    // reset mid-stall (skid full when enabled)
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 10'h011;
    in_data = 16'h51;
    step();
    out_ready = 1'b0; in_data = 16'h52;
    step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_cnt", 64'(stall_cnt), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h77;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'h77);
    in_valid = 1'b0;
    step();
    step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("end_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
